pong_game_ctrl: RTL and testbench

Game sequencer for the Pong design. Runs the match state machine (idle, serve, play, point pause, game over) and keeps both scores. Moves both paddles from button inputs once per frame and tells the ball datapath when to reload, which way to serve and when to move. Sits between the button synchroniser and the image/ball generator, clocked by the 25 MHz pixel clock.

---
 rtl/pong_game_ctrl_if.sv | 35 +++
 rtl/pong_game_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong game sequencer and the rest of the design.
// The slave modport is the sequencer. The master modport is the button and ball side.
interface pong_game_ctrl_if;
  logic        frame_tick;
  logic        btn_start;
  logic        btn_p1_up;
  logic        btn_p1_down;
  logic        btn_p2_up;
  logic        btn_p2_down;
  logic [11:0] ball_x_pos;
  logic [11:0] ball_y_pos;
  logic        ball_run;
  logic        ball_load;
  logic        serve_left;
  logic [11:0] player_1_y_pos;
  logic [11:0] player_2_y_pos;
  logic [3:0]  score_1;
  logic [3:0]  score_2;
  logic [2:0]  game_state;
  logic [1:0]  winner;

  modport master (
    output frame_tick, btn_start, btn_p1_up, btn_p1_down, btn_p2_up, btn_p2_down,
    output ball_x_pos, ball_y_pos,
    input  ball_run, ball_load, serve_left, player_1_y_pos, player_2_y_pos,
    input  score_1, score_2, game_state, winner
  );

  modport slave (
    input  frame_tick, btn_start, btn_p1_up, btn_p1_down, btn_p2_up, btn_p2_down,
    input  ball_x_pos, ball_y_pos,
    output ball_run, ball_load, serve_left, player_1_y_pos, player_2_y_pos,
    output score_1, score_2, game_state, winner
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: game FSM, scores, paddle motion and ball load/run control.
// Define PONG_AI_PLAYER_2_EN to have player 2 track the ball instead of its buttons.
module pong_game_ctrl #(
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_FRAMES  = 60,
  parameter int POINT_FRAMES  = 90,
  parameter int PADDLE_STEP   = 4,
  parameter int PADDLE_Y_INIT = 210,
  parameter int PADDLE_Y_MAX  = 420,
  parameter int GOAL_LEFT_X   = 4,
  parameter int GOAL_RIGHT_X  = 627
) (
  input logic             CLOCK_25,
  input logic             RESET_N,
  pong_game_ctrl_if.slave bus
);
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_SERVE = 3'd1;
  localparam logic [2:0]  ST_PLAY  = 3'd2;
  localparam logic [2:0]  ST_POINT = 3'd3;
  localparam logic [2:0]  ST_OVER  = 3'd4;
  localparam logic [3:0]  WIN_S    = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_C  = 16'(SERVE_FRAMES);
  localparam logic [15:0] POINT_C  = 16'(POINT_FRAMES);
  localparam logic [11:0] STEP     = 12'(PADDLE_STEP);
  localparam logic [11:0] Y_INIT   = 12'(PADDLE_Y_INIT);
  localparam logic [11:0] Y_MAX    = 12'(PADDLE_Y_MAX);
  localparam logic [11:0] GOAL_L   = 12'(GOAL_LEFT_X);
  localparam logic [11:0] GOAL_R   = 12'(GOAL_RIGHT_X);

  // Compare before subtracting/adding so the 12-bit position never wraps.
  function automatic logic [11:0] paddle_move(input logic [11:0] y, input logic up, input logic dn);
    logic [12:0] sum;
    sum = {1'b0, y} + {1'b0, STEP};
    if (up && !dn) begin
      if (y < STEP) paddle_move = 12'd0;
      else          paddle_move = y - STEP;
    end else if (dn && !up) begin
      if (sum > {1'b0, Y_MAX}) paddle_move = Y_MAX;
      else                     paddle_move = sum[11:0];
    end else begin
      paddle_move = y;
    end
  endfunction

  logic [2:0]  state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic        start_q_r;
  logic        ball_run_r, ball_run_nxt_s;
  logic        ball_load_r, ball_load_nxt_s;
  logic        serve_left_r, serve_left_nxt_s;
  logic [11:0] p1_r, p1_nxt_s, p2_r, p2_nxt_s;
  logic [3:0]  s1_r, s1_nxt_s, s2_r, s2_nxt_s;
  logic [1:0]  winner_r, winner_nxt_s;
  logic        start_edge_s, tick_s, goal_l_s, goal_r_s, goal_any_s, win_s;
  logic        p2_up_s, p2_dn_s;
  logic [3:0]  s1_inc_s, s2_inc_s;

  assign start_edge_s = bus.btn_start & ~start_q_r;
  assign tick_s       = bus.frame_tick;
  assign goal_l_s     = (bus.ball_x_pos <= GOAL_L);
  assign goal_r_s     = (bus.ball_x_pos >= GOAL_R);
  assign goal_any_s   = goal_l_s | goal_r_s;
  assign s1_inc_s     = s1_r + 4'd1;
  assign s2_inc_s     = s2_r + 4'd1;
  assign win_s        = goal_l_s ? (s2_inc_s == WIN_S) : (s1_inc_s == WIN_S);

`ifdef PONG_AI_PLAYER_2_EN
  // Player 2 chases the ball centre against the paddle centre.
  assign p2_up_s = ({1'b0, bus.ball_y_pos} + 13'd4) < ({1'b0, p2_r} + 13'd30);
  assign p2_dn_s = ({1'b0, bus.ball_y_pos} + 13'd4) > ({1'b0, p2_r} + 13'd30);
  logic unused_s;
  assign unused_s = bus.btn_p2_up ^ bus.btn_p2_down;
`else
  assign p2_up_s = bus.btn_p2_up;
  assign p2_dn_s = bus.btn_p2_down;
  logic unused_s;
  assign unused_s = ^bus.ball_y_pos;
`endif

  // FSM state register
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start_edge_s) state_nxt_s = ST_SERVE;
        else              state_nxt_s = state_r;
      end
      ST_SERVE: begin
        if (tick_s && (cnt_r <= 16'd1)) state_nxt_s = ST_PLAY;
        else                            state_nxt_s = ST_SERVE;
      end
      ST_PLAY: begin
        if (tick_s && goal_any_s) state_nxt_s = win_s ? ST_OVER : ST_POINT;
        else                      state_nxt_s = ST_PLAY;
      end
      ST_POINT: begin
        if (tick_s && (cnt_r <= 16'd1)) state_nxt_s = ST_SERVE;
        else                            state_nxt_s = ST_POINT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of counter, scores, paddles and ball controls
  always_comb begin
    cnt_nxt_s        = cnt_r;
    s1_nxt_s         = s1_r;
    s2_nxt_s         = s2_r;
    winner_nxt_s     = winner_r;
    serve_left_nxt_s = serve_left_r;
    p1_nxt_s         = p1_r;
    p2_nxt_s         = p2_r;
    ball_load_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start_edge_s) begin
          s1_nxt_s         = 4'd0;
          s2_nxt_s         = 4'd0;
          winner_nxt_s     = 2'b00;
          serve_left_nxt_s = 1'b0;
          p1_nxt_s         = Y_INIT;
          p2_nxt_s         = Y_INIT;
          cnt_nxt_s        = SERVE_C;
          ball_load_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_SERVE, ST_PLAY, ST_POINT: begin
        if (tick_s) begin
          p1_nxt_s = paddle_move(p1_r, bus.btn_p1_up, bus.btn_p1_down);
          p2_nxt_s = paddle_move(p2_r, p2_up_s, p2_dn_s);
          if (state_r == ST_PLAY) begin
            if (goal_l_s) begin
              s2_nxt_s         = s2_inc_s;
              serve_left_nxt_s = 1'b1;
            end else if (goal_r_s) begin
              s1_nxt_s         = s1_inc_s;
              serve_left_nxt_s = 1'b0;
            end else begin
              s1_nxt_s = s1_r;
            end
            if (goal_any_s && win_s)  winner_nxt_s = goal_l_s ? 2'b10 : 2'b01;
            else if (goal_any_s)      cnt_nxt_s    = POINT_C;
            else                      cnt_nxt_s    = cnt_r;
          end else if ((state_r == ST_POINT) && (cnt_r <= 16'd1)) begin
            cnt_nxt_s       = SERVE_C;
            ball_load_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r - 16'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: cnt_nxt_s = 16'd0;
    endcase
    ball_run_nxt_s = (state_nxt_s == ST_PLAY);
  end

  // Registered datapath and outputs
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r        <= 16'd0;
      start_q_r    <= 1'b0;
      ball_run_r   <= 1'b0;
      ball_load_r  <= 1'b0;
      serve_left_r <= 1'b0;
      p1_r         <= Y_INIT;
      p2_r         <= Y_INIT;
      s1_r         <= 4'd0;
      s2_r         <= 4'd0;
      winner_r     <= 2'b00;
    end else begin
      cnt_r        <= cnt_nxt_s;
      start_q_r    <= bus.btn_start;
      ball_run_r   <= ball_run_nxt_s;
      ball_load_r  <= ball_load_nxt_s;
      serve_left_r <= serve_left_nxt_s;
      p1_r         <= p1_nxt_s;
      p2_r         <= p2_nxt_s;
      s1_r         <= s1_nxt_s;
      s2_r         <= s2_nxt_s;
      winner_r     <= winner_nxt_s;
    end
  end

  assign bus.ball_run       = ball_run_r;
  assign bus.ball_load      = ball_load_r;
  assign bus.serve_left     = serve_left_r;
  assign bus.player_1_y_pos = p1_r;
  assign bus.player_2_y_pos = p2_r;
  assign bus.score_1        = s1_r;
  assign bus.score_2        = s2_r;
  assign bus.game_state     = state_r;
  assign bus.winner         = winner_r;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed match scenarios plus random play, all
// checked each cycle against a rule-level game model.
module tb_pong_game_ctrl;
  logic CLOCK_25 = 1'b0;
  logic RESET_N  = 1'b0;
  pong_game_ctrl_if pg_if();

  pong_game_ctrl dut (.CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .bus(pg_if.slave));

  always #20 CLOCK_25 = ~CLOCK_25;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Game model state
  int m_state = 0, m_cnt = 0, m_s1 = 0, m_s2 = 0, m_win = 0;
  int m_p1 = 210, m_p2 = 210;
  bit m_sl = 1'b0, m_load = 1'b0, m_run = 1'b0, m_prev_start = 1'b0;

  function automatic int move(int y, bit up, bit dn);
    if (up && !dn) return (y < 4) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 420) ? 420 : y + 4;
    return y;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rule-level model: advance the game by one clock using the driven inputs
  always @(posedge CLOCK_25) begin
    bit start_edge, ft, p2u, p2d;
    int x, y;
    if (!RESET_N) begin
      m_state = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_p1 = 210; m_p2 = 210; m_sl = 0; m_load = 0; m_run = 0; m_prev_start = 0;
    end else begin
      start_edge   = pg_if.btn_start && !m_prev_start;
      m_prev_start = pg_if.btn_start;
      ft = pg_if.frame_tick;
      x  = int'(pg_if.ball_x_pos);
      y  = int'(pg_if.ball_y_pos);
`ifdef PONG_AI_PLAYER_2_EN
      p2u = (y + 4 < m_p2 + 30);
      p2d = (y + 4 > m_p2 + 30);
`else
      p2u = pg_if.btn_p2_up;
      p2d = pg_if.btn_p2_down;
`endif
      m_load = 0;
      if (m_state == 0 || m_state == 4) begin
        if (start_edge) begin
          m_s1 = 0; m_s2 = 0; m_win = 0; m_p1 = 210; m_p2 = 210;
          m_sl = 0; m_cnt = 60; m_load = 1; m_state = 1;
        end
      end else if (ft) begin
        m_p1 = move(m_p1, pg_if.btn_p1_up, pg_if.btn_p1_down);
        m_p2 = move(m_p2, p2u, p2d);
        if (m_state == 1) begin
          if (m_cnt == 1) m_state = 2;
          m_cnt--;
        end else if (m_state == 3) begin
          if (m_cnt == 1) begin m_state = 1; m_cnt = 60; m_load = 1; end
          else m_cnt--;
        end else if (x <= 4 || x >= 627) begin
          if (x <= 4) begin m_s2++; m_sl = 1; end
          else        begin m_s1++; m_sl = 0; end
          if (m_s1 == 7 || m_s2 == 7) begin m_state = 4; m_win = (x <= 4) ? 2 : 1; end
          else begin m_state = 3; m_cnt = 90; end
        end
      end
      m_run = (m_state == 2);
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge CLOCK_25) begin
    if (RESET_N && chk_en) begin
      cmp("game_state", int'(pg_if.game_state), m_state);
      cmp("ball_run", int'(pg_if.ball_run), int'(m_run));
      cmp("ball_load", int'(pg_if.ball_load), int'(m_load));
      cmp("serve_left", int'(pg_if.serve_left), int'(m_sl));
      cmp("p1_y", int'(pg_if.player_1_y_pos), m_p1);
      cmp("p2_y", int'(pg_if.player_2_y_pos), m_p2);
      cmp("score_1", int'(pg_if.score_1), m_s1);
      cmp("score_2", int'(pg_if.score_2), m_s2);
      cmp("winner", int'(pg_if.winner), m_win);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge CLOCK_25);
  endtask

  task automatic chk_reset_vals(input string tag);
    cmp({tag, "_state"}, int'(pg_if.game_state), 0);
    cmp({tag, "_run"}, int'(pg_if.ball_run), 0);
    cmp({tag, "_load"}, int'(pg_if.ball_load), 0);
    cmp({tag, "_sl"}, int'(pg_if.serve_left), 0);
    cmp({tag, "_p1"}, int'(pg_if.player_1_y_pos), 210);
    cmp({tag, "_p2"}, int'(pg_if.player_2_y_pos), 210);
    cmp({tag, "_s1"}, int'(pg_if.score_1), 0);
    cmp({tag, "_s2"}, int'(pg_if.score_2), 0);
    cmp({tag, "_win"}, int'(pg_if.winner), 0);
  endtask

  initial begin
    pg_if.frame_tick = 0; pg_if.btn_start = 0;
    pg_if.btn_p1_up = 0; pg_if.btn_p1_down = 0; pg_if.btn_p2_up = 0; pg_if.btn_p2_down = 0;
    pg_if.ball_x_pos = 12'd320; pg_if.ball_y_pos = 12'd240;
    run(3);
    RESET_N = 1'b1;
    chk_en  = 1'b1;
    chk_reset_vals("rst");

    // Start, serve countdown, release
    pg_if.btn_start = 1; run(1);
    cmp("start_state", int'(pg_if.game_state), 1);
    cmp("start_load", int'(pg_if.ball_load), 1);
    pg_if.btn_start = 0; run(1);
    cmp("start_load_low", int'(pg_if.ball_load), 0);
    pg_if.frame_tick = 1; run(59);
    cmp("serve_59", int'(pg_if.game_state), 1);
    run(1);
    cmp("play_state", int'(pg_if.game_state), 2);
    cmp("play_run", int'(pg_if.ball_run), 1);

    // Left goal and point pause
    pg_if.ball_x_pos = 12'd3; run(1);
    pg_if.ball_x_pos = 12'd320;
    cmp("lgoal_s2", int'(pg_if.score_2), 1);
    cmp("lgoal_sl", int'(pg_if.serve_left), 1);
    cmp("lgoal_state", int'(pg_if.game_state), 3);
    cmp("lgoal_run", int'(pg_if.ball_run), 0);
    run(89);
    cmp("point_89", int'(pg_if.game_state), 3);
    run(1);
    cmp("reserve_state", int'(pg_if.game_state), 1);
    cmp("reserve_load", int'(pg_if.ball_load), 1);
    run(60);

    // Seven right goals win the match for player 1
    for (int i = 0; i < 7; i++) begin
      pg_if.ball_x_pos = 12'd630; run(1);
      pg_if.ball_x_pos = 12'd320;
      if (i < 6) run(150);
    end
    cmp("over_s1", int'(pg_if.score_1), 7);
    cmp("over_win", int'(pg_if.winner), 1);
    cmp("over_state", int'(pg_if.game_state), 4);
    run(5);
    cmp("over_hold", int'(pg_if.game_state), 4);

    // Restart with start held high afterwards
    pg_if.btn_start = 1; run(1);
    cmp("restart_state", int'(pg_if.game_state), 1);
    cmp("restart_s1", int'(pg_if.score_1), 0);
    cmp("restart_win", int'(pg_if.winner), 0);
    run(60);
    cmp("held_start_play", int'(pg_if.game_state), 2);

    // Paddle clamping and both-button hold
    pg_if.btn_p1_down = 1; run(52);
    cmp("p1_418", int'(pg_if.player_1_y_pos), 418);
    pg_if.btn_p1_down = 0; pg_if.btn_p1_up = 1; run(104);
    cmp("p1_2", int'(pg_if.player_1_y_pos), 2);
    run(1);
    cmp("p1_clamp0", int'(pg_if.player_1_y_pos), 0);
    run(1);
    cmp("p1_stay0", int'(pg_if.player_1_y_pos), 0);
    pg_if.btn_p1_up = 0; pg_if.btn_p1_down = 1; run(105);
    cmp("p1_420", int'(pg_if.player_1_y_pos), 420);
    run(1);
    cmp("p1_stay420", int'(pg_if.player_1_y_pos), 420);
    pg_if.btn_p1_up = 1; run(3);
    cmp("p1_both", int'(pg_if.player_1_y_pos), 420);
    pg_if.btn_p1_up = 0; pg_if.btn_p1_down = 0;

    // Fresh start press during PLAY is ignored
    pg_if.btn_start = 0; run(1);
    pg_if.btn_start = 1; run(1);
    pg_if.btn_start = 0;
    cmp("play_press_state", int'(pg_if.game_state), 2);
    cmp("play_press_load", int'(pg_if.ball_load), 0);
    cmp("play_press_s1", int'(pg_if.score_1), 0);

    // Asynchronous reset in the middle of POINT
    pg_if.ball_x_pos = 12'd3; run(1);
    pg_if.ball_x_pos = 12'd320; run(10);
    cmp("pre_rst_state", int'(pg_if.game_state), 3);
    #2 RESET_N = 1'b0;
    #1 chk_reset_vals("async");
    pg_if.frame_tick = 0;
    run(2);
    RESET_N = 1'b1;

`ifdef PONG_AI_PLAYER_2_EN
    pg_if.btn_start = 1; run(1);
    pg_if.btn_start = 0; pg_if.frame_tick = 1;
    pg_if.ball_y_pos = 12'd100; pg_if.btn_p2_down = 1; run(1);
    cmp("ai_p2", int'(pg_if.player_2_y_pos), 206);
    pg_if.btn_p2_down = 0;
`endif

    // Random play against the model
    for (int c = 0; c < 6000; c++) begin
      int r;
      pg_if.frame_tick = ($urandom_range(0, 1) == 1);
      pg_if.btn_start  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) begin
        pg_if.btn_p1_up = $urandom_range(0, 1); pg_if.btn_p1_down = $urandom_range(0, 1);
        pg_if.btn_p2_up = $urandom_range(0, 1); pg_if.btn_p2_down = $urandom_range(0, 1);
      end
      r = $urandom_range(0, 7);
      if (r == 0)      pg_if.ball_x_pos = 12'($urandom_range(0, 4));
      else if (r == 1) pg_if.ball_x_pos = 12'($urandom_range(627, 700));
      else             pg_if.ball_x_pos = 12'($urandom_range(5, 626));
      pg_if.ball_y_pos = 12'($urandom_range(0, 479));
      run(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
